// File: rtl/way_fetch_scheduler_if.sv
// rtl/way_fetch_scheduler_if.sv - read request, tagged return and sorter-input bundle
interface way_fetch_scheduler_if #(
    parameter int IDXW = 4,
    parameter int BW   = 512
);
    logic            REQ_VALID;
    logic            REQ_READY;
    logic [IDXW-1:0] REQ_IDX;
    logic            RSP_EN;
    logic [IDXW-1:0] RSP_IDX;
    logic [BW-1:0]   RSP_DATA;
    logic [BW-1:0]   DOT;
    logic            DOTEN;
    logic [IDXW-1:0] DOT_IDX;

    modport master (
        output REQ_VALID, REQ_IDX, DOT, DOTEN, DOT_IDX,
        input  REQ_READY, RSP_EN, RSP_IDX, RSP_DATA
    );

    modport slave (
        input  REQ_VALID, REQ_IDX, DOT, DOTEN, DOT_IDX,
        output REQ_READY, RSP_EN, RSP_IDX, RSP_DATA
    );
endinterface

// File: rtl/way_fetch_scheduler.sv
// rtl/way_fetch_scheduler.sv - round-robin per-way beat fetcher feeding the hybrid sorter
module way_fetch_scheduler #(
    parameter int W_LOG = 2,
    parameter int E_LOG = 2,
    parameter int P_LOG = 3,
    parameter int DATW  = 64,
    parameter int NUMW  = 32,
    parameter int HOLD  = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              START,
    input  logic [NUMW-1:0]                   ECNT_PER_WAY,
    input  logic [(1<<(E_LOG+W_LOG))-1:0]     EMP,
    way_fetch_scheduler_if.master             bus,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              ERR
);
    localparam int IDXW = E_LOG + W_LOG;
    localparam int NW   = 1 << IDXW;
    localparam int BW   = DATW << P_LOG;
    localparam logic [3:0] HOLD_V = 4'(HOLD);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [NW-1:0]   r_pending;
    logic [3:0]      r_hold [NW];
    logic [NUMW-1:0] r_remaining [NW];
    logic [IDXW-1:0] r_ptr;
    logic            r_req_valid;
    logic [IDXW-1:0] r_req_idx;
    logic            r_doten;
    logic [IDXW-1:0] r_dot_idx;
    logic [BW-1:0]   r_dot;
    logic            r_err;

    logic [BW-1:0]   w_rsp_data;
    logic            w_hs;
    logic            w_rsp_hit;
    logic            w_rsp_bad;
    logic [NW-1:0]   w_elig;
    logic [NW-1:0]   w_hs_mask;
    logic [NW-1:0]   w_cand;
    logic            w_any_rem;
    logic            w_pick_go;
    logic            w_pick_found;
    logic [IDXW-1:0] w_pick_idx;
    logic            w_finish;

    assign w_rsp_data = bus.RSP_DATA;
    assign w_hs       = r_req_valid & bus.REQ_READY;
    assign w_rsp_hit  = bus.RSP_EN & r_pending[bus.RSP_IDX];
    assign w_rsp_bad  = bus.RSP_EN & ~r_pending[bus.RSP_IDX];

    always_comb begin
        w_elig    = '0;
        w_any_rem = 1'b0;
        for (int w = 0; w < NW; w++) begin
            w_elig[w] = EMP[w] & ~r_pending[w] & (r_hold[w] == 4'd0)
                      & (r_remaining[w] != '0) & (r_state == S_RUN);
            if (r_remaining[w] != '0) begin
                w_any_rem = 1'b1;
            end
        end
    end

    // The way handshaking this cycle is still marked non-pending, so mask it out of the pick.
    assign w_hs_mask = w_hs ? (NW'(1) << r_req_idx) : {NW{1'b0}};
    assign w_cand    = w_elig & ~w_hs_mask;
    assign w_pick_go = ~r_req_valid | w_hs;

    // Descending scan so the lowest offset from r_ptr wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int i = NW - 1; i >= 0; i--) begin
            if (w_cand[r_ptr + IDXW'(i)]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = r_ptr + IDXW'(i);
            end
        end
    end

    assign w_finish = (r_state == S_RUN) & ~w_any_rem & (r_pending == '0)
                    & ~r_req_valid & ~bus.RSP_EN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_ptr       <= '0;
            r_req_valid <= 1'b0;
            r_req_idx   <= '0;
            r_doten     <= 1'b0;
            r_dot_idx   <= '0;
            r_err       <= 1'b0;
            for (int w = 0; w < NW; w++) begin
                r_hold[w]      <= 4'd0;
                r_remaining[w] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state <= (ECNT_PER_WAY == '0) ? S_DONE : S_RUN;
                        for (int w = 0; w < NW; w++) begin
                            r_remaining[w] <= ECNT_PER_WAY;
                        end
                    end
                end
                S_RUN: begin
                    if (w_finish) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_hs) begin
                r_pending[r_req_idx]   <= 1'b1;
                r_remaining[r_req_idx] <= r_remaining[r_req_idx] - NUMW'(1);
                r_ptr                  <= r_req_idx + IDXW'(1);
            end
            if (w_rsp_hit) begin
                r_pending[bus.RSP_IDX] <= 1'b0;
            end

            for (int w = 0; w < NW; w++) begin
                if (w_rsp_hit && (bus.RSP_IDX == IDXW'(w))) begin
                    r_hold[w] <= HOLD_V;
                end else if (r_hold[w] != 4'd0) begin
                    r_hold[w] <= r_hold[w] - 4'd1;
                end
            end

            if (w_pick_go) begin
                r_req_valid <= w_pick_found;
                if (w_pick_found) begin
                    r_req_idx <= w_pick_idx;
                end
            end

            r_doten <= w_rsp_hit;
            if (w_rsp_hit) begin
                r_dot_idx <= bus.RSP_IDX;
            end
            if (w_rsp_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_rsp_hit) begin
            r_dot <= w_rsp_data;
        end
    end

    assign bus.REQ_VALID = r_req_valid;
    assign bus.REQ_IDX   = r_req_idx;
    assign bus.DOT       = r_dot;
    assign bus.DOTEN     = r_doten;
    assign bus.DOT_IDX   = r_dot_idx;
    assign BUSY          = (r_state == S_RUN);
    assign DONE          = (r_state == S_DONE);
    assign ERR           = r_err;
endmodule

// File: tb/tb_way_fetch_scheduler.sv
// tb/tb_way_fetch_scheduler.sv - randomized scoreboard bench for way_fetch_scheduler
module tb_way_fetch_scheduler;
    localparam int W_LOG = 2;
    localparam int E_LOG = 2;
    localparam int P_LOG = 3;
    localparam int DATW  = 64;
    localparam int NUMW  = 32;
    localparam int HOLD  = 4;
    localparam int IDXW  = E_LOG + W_LOG;
    localparam int NW    = 1 << IDXW;
    localparam int BW    = DATW << P_LOG;

    logic            CLK = 1'b0;
    logic            RST;
    logic            START;
    logic [NUMW-1:0] ECNT_PER_WAY;
    logic [NW-1:0]   EMP;
    logic            BUSY;
    logic            DONE;
    logic            ERR;

    way_fetch_scheduler_if #(.IDXW(IDXW), .BW(BW)) bus ();

    way_fetch_scheduler #(
        .W_LOG(W_LOG), .E_LOG(E_LOG), .P_LOG(P_LOG),
        .DATW(DATW), .NUMW(NUMW), .HOLD(HOLD)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .ECNT_PER_WAY(ECNT_PER_WAY),
        .EMP(EMP), .bus(bus), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int            sb_idx[$];
    logic [BW-1:0] sb_data[$];

    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] d;
        for (int i = 0; i < BW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    always @(negedge CLK) begin : monitor
        int            ei;
        logic [BW-1:0] ed;
        if (!RST && bus.DOTEN) begin
            if (sb_idx.size() == 0) begin
                check("dot_unexpected", 1, 0);
            end else begin
                ei = sb_idx.pop_front();
                ed = sb_data.pop_front();
                check("dot_idx", bus.DOT_IDX, ei);
                check("dot_data", bus.DOT, ed);
            end
        end
    end

    // emp_mode: 0 all empty, 1 only way 5 for 60 cycles, 2 random
    // rdy_mode: 0 always ready, 1 random, 2 stall the first request for 10 cycles
    task automatic run_pass(input string tag, input int ecnt, input int emp_mode, input int rdy_mode,
                            input int lat_min, input int lat_max, input int stop_hs, input bit check_seq);
        int  req_cnt[NW];
        bit  outst[NW];
        int  last_rsp[NW];
        int  due_q[$];
        int  due_idx[$];
        int  hs_iter[$];
        int  hs_idx[$];
        int  n_hs = 0, done_iter = -1, last_dot = -1, start_iter, stall = 0, held_idx = -1;
        int  rv_seen = 0, idx, bad_ways, others;
        bit  finished = 0, ok;
        logic [BW-1:0] d;
        for (int w = 0; w < NW; w++) begin
            req_cnt[w] = 0; outst[w] = 0; last_rsp[w] = -1000;
        end
        ECNT_PER_WAY = ecnt; START = 1; EMP = '1; bus.REQ_READY = 0; bus.RSP_EN = 0;
        start_iter = cyc;
        tick();
        START = 0;
        check({tag, "_busy_after_start"}, BUSY, ecnt != 0);
        for (int n = 0; n < 3000 && !finished; n++) begin
            if (stop_hs != 0 && n_hs >= stop_hs) begin
                bus.REQ_READY = 0;
                return;
            end
            if (bus.REQ_VALID) rv_seen++;
            if (bus.DOTEN) last_dot = cyc;
            if (DONE) begin
                done_iter = cyc;
                finished  = 1;
            end else begin
                case (emp_mode)
                    0: EMP = '1;
                    1: EMP = (n < 60) ? NW'(1 << 5) : '1;
                    default: EMP = NW'($urandom);
                endcase
                if (emp_mode == 1 && n == 60) begin
                    others = 0;
                    for (int w = 0; w < NW; w++) if (w != 5) others += req_cnt[w];
                    check({tag, "_way5_reqs"}, req_cnt[5], 3);
                    check({tag, "_other_reqs"}, others, 0);
                end
                case (rdy_mode)
                    0: bus.REQ_READY = 1;
                    1: bus.REQ_READY = ($urandom_range(0, 3) != 0);
                    default: begin
                        if (bus.REQ_VALID && stall <= 10) begin
                            if (stall == 0) begin
                                held_idx = bus.REQ_IDX;
                            end else begin
                                check({tag, "_stall_valid"}, bus.REQ_VALID, 1);
                                check({tag, "_stall_idx"}, bus.REQ_IDX, held_idx);
                            end
                            stall++;
                            EMP = NW'($urandom);
                        end
                        bus.REQ_READY = (stall > 10);
                    end
                endcase
                bus.RSP_EN = 0;
                for (int j = 0; j < due_q.size(); j++) begin
                    if (due_q[j] <= cyc) begin
                        idx = due_idx[j];
                        d   = rand_beat();
                        bus.RSP_EN = 1; bus.RSP_IDX = IDXW'(idx); bus.RSP_DATA = d;
                        sb_idx.push_back(idx); sb_data.push_back(d);
                        outst[idx] = 0; last_rsp[idx] = cyc + 1;
                        due_q.delete(j); due_idx.delete(j);
                        break;
                    end
                end
                if (bus.REQ_VALID && bus.REQ_READY) begin
                    idx = bus.REQ_IDX;
                    check({tag, "_hs_not_outstanding"}, outst[idx], 0);
                    check({tag, "_hs_within_count"}, req_cnt[idx] < ecnt, 1);
                    check({tag, "_hs_hold_gap"}, (cyc + 1 - last_rsp[idx]) >= HOLD, 1);
                    if (rdy_mode == 2 && n_hs == 0) check({tag, "_stall_hs_idx"}, idx, held_idx);
                    outst[idx] = 1; req_cnt[idx]++; n_hs++;
                    hs_iter.push_back(cyc); hs_idx.push_back(idx);
                    due_q.push_back(cyc + $urandom_range(lat_min, lat_max)); due_idx.push_back(idx);
                end
                tick();
            end
        end
        if (!finished) check({tag, "_done_timeout"}, 0, 1);
        bus.RSP_EN = 0; bus.REQ_READY = 0;
        tick();
        check({tag, "_done_one_cycle"}, DONE, 0);
        check({tag, "_busy_after_done"}, BUSY, 0);
        bad_ways = 0;
        for (int w = 0; w < NW; w++) if (req_cnt[w] != ecnt) bad_ways++;
        check({tag, "_ways_short"}, bad_ways, 0);
        check({tag, "_sb_left"}, sb_idx.size(), 0);
        if (ecnt > 0) begin
            check({tag, "_done_after_last_dot"}, done_iter - last_dot, 1);
        end else begin
            check({tag, "_zero_no_req"}, rv_seen, 0);
            check({tag, "_zero_done_lat"}, (done_iter - start_iter >= 1) && (done_iter - start_iter <= 2), 1);
        end
        if (check_seq) begin
            ok = (hs_idx.size() == NW * ecnt);
            for (int i = 0; i < hs_idx.size(); i++) begin
                if (hs_idx[i] != i % NW || hs_iter[i] != hs_iter[0] + i) ok = 0;
            end
            check({tag, "_rr_sequence"}, ok, 1);
        end
    endtask

    initial begin
        RST = 1; START = 0; ECNT_PER_WAY = '0; EMP = '0;
        bus.REQ_READY = 0; bus.RSP_EN = 0; bus.RSP_IDX = '0; bus.RSP_DATA = '0;
        tick(); tick();
        RST = 0;
        check("rst_req_valid", bus.REQ_VALID, 0);
        check("rst_req_idx", bus.REQ_IDX, 0);
        check("rst_doten", bus.DOTEN, 0);
        check("rst_dot_idx", bus.DOT_IDX, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);

        run_pass("full", 1, 0, 0, 3, 3, 0, 1);
        check("full_err", ERR, 0);

        run_pass("zero", 0, 0, 0, 1, 1, 0, 0);

        bus.RSP_EN = 1; bus.RSP_IDX = IDXW'(7); bus.RSP_DATA = rand_beat();
        tick();
        bus.RSP_EN = 0;
        check("spur_doten", bus.DOTEN, 0);
        check("spur_err", ERR, 1);

        run_pass("way5", 3, 1, 0, 2, 2, 0, 0);
        check("err_sticky", ERR, 1);

        RST = 1; tick(); RST = 0;
        check("err_cleared", ERR, 0);

        run_pass("stall", 2, 0, 2, 1, 4, 0, 0);

        for (int p = 0; p < 3; p++) begin
            run_pass("rand", $urandom_range(1, 3), 2, 1, 1, 6, 0, 0);
            check("rand_err", ERR, 0);
        end

        run_pass("midrst", 2, 0, 0, 1000, 1000, 4, 0);
        RST = 1; bus.REQ_READY = 0;
        tick();
        check("midrst_req_valid", bus.REQ_VALID, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_done", DONE, 0);
        RST = 0;
        sb_idx.delete(); sb_data.delete();
        bus.RSP_EN = 1; bus.RSP_IDX = '0; bus.RSP_DATA = rand_beat();
        tick();
        bus.RSP_EN = 0;
        check("inflight_err", ERR, 1);
        check("inflight_doten", bus.DOTEN, 0);
        RST = 1; tick(); RST = 0;
        run_pass("restart", 1, 0, 0, 3, 3, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
